// File: rtl/riscv_dmem_ctrl_if.sv
// Request/response bus between the MEM stage and the handshaked data memory.
// Loads and stores travel one at a time over valid/ready; the response is a one-cycle strobe.
interface riscv_dmem_ctrl_if #(
    parameter int ADDR_WIDTH = 15
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic                  busy;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/riscv_dmem_ctrl.sv
// Handshaked RV32 data memory: byte-lane stores, sign/zero-extended loads,
// programmable wait states, and error flagging for misaligned or illegal accesses.
module riscv_dmem_ctrl #(
    parameter int DLY_FF      = 1,
    parameter int ADDR_WIDTH  = 15,
    parameter int WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    riscv_dmem_ctrl_if.slave   bus
);
    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15 || DLY_FF < 0) begin : g_bad_param
        $error("riscv_dmem_ctrl: WAIT_CYCLES must be 0..15 and DLY_FF non-negative");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state;
    state_t                nxt_state;
    logic [3:0]            cnt;
    logic                  accept;
    logic                  access;

    logic                  we_p0;
    logic [2:0]            funct3_p0;
    logic [ADDR_WIDTH-1:0] addr_p0;
    logic [31:0]           wdata_p0;

    logic [1:0]            lane;
    logic [ADDR_WIDTH-3:0] word_idx;
    logic [31:0]           rd_word;
    logic                  acc_err;
    logic [3:0]            be;
    logic [31:0]           wlanes;

    logic                  rsp_valid;
    logic                  rsp_err;
    logic [31:0]           rsp_rdata;

    logic [31:0]           mem [DEPTH];

    function automatic logic [31:0] load_ext(input logic [31:0] word,
                                             input logic [1:0]  sel,
                                             input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {sel, 3'b000});
        h = sel[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b100:  load_ext = {24'd0, b};
            3'b101:  load_ext = {16'd0, h};
            default: load_ext = word;
        endcase
    endfunction

    assign accept        = bus.req_valid && (state == IDLE);
    assign access        = (state == WAIT) && (cnt == 4'd0);
    assign bus.req_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_err   = rsp_err;
    assign bus.rsp_rdata = rsp_rdata;

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:    if (bus.req_valid) nxt_state = WAIT;
            WAIT:    if (cnt == 4'd0) nxt_state = RESP;
            RESP:    nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
        end else begin
            state     <= nxt_state;
            rsp_valid <= 1'b0;
            if (accept) begin
                cnt <= 4'(WAIT_CYCLES);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                rsp_valid <= 1'b1;
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_err || we_p0) ? 32'd0 : load_ext(rd_word, lane, funct3_p0);
            end
        end
    end

    // Stage p0: request captured at acceptance, held until the access edge
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0     <= bus.req_we;
            funct3_p0 <= bus.req_funct3;
            addr_p0   <= bus.req_addr;
            wdata_p0  <= bus.req_wdata;
        end
    end

    assign lane     = addr_p0[1:0];
    assign word_idx = addr_p0[ADDR_WIDTH-1:2];
    assign rd_word  = mem[word_idx];

    always_comb begin
        acc_err = 1'b0;
        be      = 4'b0000;
        wlanes  = wdata_p0;
        case (funct3_p0)
            3'b000: begin
                be     = 4'b0001 << lane;
                wlanes = {4{wdata_p0[7:0]}};
            end
            3'b001: begin
                acc_err = addr_p0[0];
                be      = addr_p0[1] ? 4'b1100 : 4'b0011;
                wlanes  = {2{wdata_p0[15:0]}};
            end
            3'b010: begin
                acc_err = |lane;
                be      = 4'b1111;
            end
            3'b100:  acc_err = we_p0;
            3'b101:  acc_err = we_p0 || addr_p0[0];
            default: acc_err = 1'b1;
        endcase
    end

    // Byte-enabled write keeps untouched lanes intact; reset on the access edge suppresses it
    always_ff @(posedge clk) begin
        if (!reset && access && we_p0 && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word_idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Scoreboard bench for riscv_dmem_ctrl: a WAIT_CYCLES=1 and a WAIT_CYCLES=0 instance
// driven with directed and random loads/stores against a byte-array memory model.
module tb_riscv_dmem_ctrl;
    localparam int AW = 15;
    localparam int W0 = 1;
    localparam int W1 = 0;

    typedef struct {
        int          at;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        int          d;
        int          at;
        int          kind;
        logic [31:0] val;
        logic [31:0] pact;
        string       name;
    } tl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst [2];
    logic          v   [2];
    logic          w   [2];
    logic [2:0]    f3  [2];
    logic [AW-1:0] ad  [2];
    logic [31:0]   wd  [2];
    logic          rdy [2];
    logic          rv  [2];
    logic          re  [2];
    logic          bsy [2];
    logic [31:0]   rd  [2];

    riscv_dmem_ctrl_if #(.ADDR_WIDTH(AW)) bus0 ();
    riscv_dmem_ctrl_if #(.ADDR_WIDTH(AW)) bus1 ();

    assign bus0.req_valid  = v[0];
    assign bus0.req_we     = w[0];
    assign bus0.req_funct3 = f3[0];
    assign bus0.req_addr   = ad[0];
    assign bus0.req_wdata  = wd[0];
    assign bus1.req_valid  = v[1];
    assign bus1.req_we     = w[1];
    assign bus1.req_funct3 = f3[1];
    assign bus1.req_addr   = ad[1];
    assign bus1.req_wdata  = wd[1];
    assign rdy[0] = bus0.req_ready;
    assign rv[0]  = bus0.rsp_valid;
    assign re[0]  = bus0.rsp_err;
    assign bsy[0] = bus0.busy;
    assign rd[0]  = bus0.rsp_rdata;
    assign rdy[1] = bus1.req_ready;
    assign rv[1]  = bus1.rsp_valid;
    assign re[1]  = bus1.rsp_err;
    assign bsy[1] = bus1.busy;
    assign rd[1]  = bus1.rsp_rdata;

    riscv_dmem_ctrl #(.DLY_FF(1), .ADDR_WIDTH(AW), .WAIT_CYCLES(W0)) u_dut_w1 (
        .clk(clk), .reset(rst[0]), .bus(bus0)
    );
    riscv_dmem_ctrl #(.DLY_FF(1), .ADDR_WIDTH(AW), .WAIT_CYCLES(W1)) u_dut_w0 (
        .clk(clk), .reset(rst[1]), .bus(bus1)
    );

    exp_t        sb0 [$];
    exp_t        sb1 [$];
    tl_t         tlq [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_edge = 0;
    logic [31:0] mdl [2][16];
    bit          k_use = 1'b0;
    logic [31:0] k_rd;
    logic        k_err;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wc(input int d);
        return (d == 0) ? W0 : W1;
    endfunction

    // Reference: memory as bytes; an access is legal by opcode table and natural alignment
    function automatic void model(input int d, input bit we, input logic [2:0] fn, input int a,
                                  input logic [31:0] data, output logic err, output logic [31:0] r);
        int          wi, lane, size;
        bit          legal;
        logic [7:0]  b [4];
        logic [31:0] val;
        wi   = a / 4;
        lane = a % 4;
        case (fn)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            3'b010:         size = 4;
            default:        size = 0;
        endcase
        legal = we ? (fn <= 3'b010) : (size != 0);
        if (!legal) err = 1'b1;
        else        err = (a % size) != 0;
        r = 32'd0;
        if (err) return;
        for (int k = 0; k < 4; k++) b[k] = mdl[d][wi][8*k +: 8];
        if (we) begin
            for (int k = 0; k < size; k++) b[lane+k] = data[8*k +: 8];
            mdl[d][wi] = {b[3], b[2], b[1], b[0]};
        end else begin
            val = 32'd0;
            for (int k = 0; k < size; k++) val[8*k +: 8] = b[lane+k];
            if (!fn[2] && size < 4 && val[8*size-1]) begin
                for (int k = size; k < 4; k++) val[8*k +: 8] = 8'hFF;
            end
            r = val;
        end
    endfunction

    task automatic expect_at(input int d, input int at, input int kind, input logic [31:0] val,
                             input string name);
        tl_t t;
        t = '{d, at, kind, val, 32'd0, name};
        tlq.push_back(t);
    endtask

    task automatic expect_pre(input int d, input int at, input logic [31:0] act,
                              input logic [31:0] val, input string name);
        tl_t t;
        t = '{d, at, 5, val, act, name};
        tlq.push_back(t);
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge
    task automatic issue(input int d, input bit we, input logic [2:0] fn, input int a,
                         input logic [31:0] data, input bit hold, input bit drop);
        exp_t        e;
        logic        err;
        logic [31:0] r;
        int          t;
        v[d] = 1'b1; w[d] = we; f3[d] = fn; ad[d] = AW'(a); wd[d] = data;
        t = 0;
        while (!rdy[d] && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (!rdy[d]) begin
            expect_pre(d, cyc + 1, 32'd1, 32'd0, "req_accept_timeout");
            v[d] = 1'b0;
            k_use = 1'b0;
            return;
        end
        acc_edge = cyc + 1;
        if (!drop) begin
            model(d, we, fn, a, data, err, r);
            if (k_use) begin
                r   = k_rd;
                err = k_err;
            end
            e = '{acc_edge + wc(d) + 1, r, err};
            if (d == 0) sb0.push_back(e);
            else        sb1.push_back(e);
        end
        k_use = 1'b0;
        @(negedge clk);
        if (!hold) v[d] = 1'b0;
    endtask

    task automatic dir(input int d, input bit we, input logic [2:0] fn, input int a,
                       input logic [31:0] data, input logic [31:0] want_rd, input logic want_err);
        k_use = 1'b1;
        k_rd  = want_rd;
        k_err = want_err;
        issue(d, we, fn, a, data, 1'b0, 1'b0);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sb0.size() != 0 || sb1.size() != 0 || !rdy[0] || !rdy[1]) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) expect_pre(0, cyc + 1, 32'd1, 32'd0, "idle_timeout");
    endtask

    // Monitor: pops the scoreboard on each response strobe and runs timeline checks
    always @(negedge clk) begin
        exp_t        e;
        tl_t         t;
        logic [31:0] act;
        for (int d = 0; d < 2; d++) begin
            if (rv[d]) begin
                checks++;
                if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
                    errors++;
                    $display("FAIL unexpected_rsp dut%0d cyc %0d: actual rsp_valid 1 required 0", d, cyc);
                end else begin
                    if (d == 0) e = sb0.pop_front();
                    else        e = sb1.pop_front();
                    if (e.at != cyc) begin
                        errors++;
                        $display("FAIL rsp_latency dut%0d: actual edge %0d required edge %0d", d, cyc, e.at);
                    end
                    checks++;
                    if (rd[d] !== e.rdata) begin
                        errors++;
                        $display("FAIL rsp_rdata dut%0d cyc %0d: actual %h required %h", d, cyc, rd[d], e.rdata);
                    end
                    checks++;
                    if (re[d] !== e.err) begin
                        errors++;
                        $display("FAIL rsp_err dut%0d cyc %0d: actual %0b required %0b", d, cyc, re[d], e.err);
                    end
                end
            end
        end
        while (tlq.size() > 0 && tlq[0].at <= cyc) begin
            t = tlq.pop_front();
            case (t.kind)
                0:       act = {31'd0, rdy[t.d]};
                1:       act = {31'd0, rv[t.d]};
                2:       act = rd[t.d];
                3:       act = {31'd0, re[t.d]};
                4:       act = {31'd0, bsy[t.d]};
                default: act = t.pact;
            endcase
            checks++;
            if (act !== t.val) begin
                errors++;
                $display("FAIL %s dut%0d cyc %0d: actual %h required %h", t.name, t.d, cyc, act, t.val);
            end
        end
    end

    initial begin
        int prev;
        int a;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; v[d] = 1'b0; w[d] = 1'b0; f3[d] = 3'd0; ad[d] = '0; wd[d] = 32'd0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            expect_at(d, cyc + 1, 0, 32'd1, "reset_req_ready");
            expect_at(d, cyc + 1, 1, 32'd0, "reset_rsp_valid");
            expect_at(d, cyc + 1, 2, 32'd0, "reset_rsp_rdata");
            expect_at(d, cyc + 1, 3, 32'd0, "reset_rsp_err");
            expect_at(d, cyc + 1, 4, 32'd0, "reset_busy");
        end
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) issue(d, 1'b1, 3'b010, i * 4, $urandom, 1'b0, 1'b0);
        wait_idle();

        // Handshake timeline around one SW on the WAIT_CYCLES=1 instance
        expect_at(0, cyc + 1, 0, 32'd0, "sw_ready_e0");
        expect_at(0, cyc + 1, 4, 32'd1, "sw_busy_e0");
        expect_at(0, cyc + 1, 1, 32'd0, "sw_valid_e0");
        expect_at(0, cyc + 2, 0, 32'd0, "sw_ready_e1");
        expect_at(0, cyc + 2, 1, 32'd0, "sw_valid_e1");
        expect_at(0, cyc + 3, 0, 32'd0, "sw_ready_e2");
        expect_at(0, cyc + 3, 1, 32'd1, "sw_valid_e2");
        expect_at(0, cyc + 4, 0, 32'd1, "sw_ready_e3");
        expect_at(0, cyc + 4, 1, 32'd0, "sw_valid_e3");
        dir(0, 1'b1, 3'b010, 'h010, 32'hDEADBEEF, 32'd0, 1'b0);
        dir(0, 1'b1, 3'b000, 'h011, 32'hFFFFFF55, 32'd0, 1'b0);
        dir(0, 1'b0, 3'b010, 'h010, 32'd0, 32'hDEAD55EF, 1'b0);
        dir(0, 1'b0, 3'b000, 'h011, 32'd0, 32'h00000055, 1'b0);
        dir(0, 1'b0, 3'b000, 'h013, 32'd0, 32'hFFFFFFDE, 1'b0);
        dir(0, 1'b0, 3'b100, 'h013, 32'd0, 32'h000000DE, 1'b0);
        dir(0, 1'b0, 3'b001, 'h012, 32'd0, 32'hFFFFDEAD, 1'b0);
        dir(0, 1'b0, 3'b101, 'h012, 32'd0, 32'h0000DEAD, 1'b0);
        dir(0, 1'b1, 3'b010, 'h012, 32'h12345678, 32'd0, 1'b1);
        dir(0, 1'b0, 3'b001, 'h011, 32'd0, 32'd0, 1'b1);
        dir(0, 1'b0, 3'b011, 'h010, 32'd0, 32'd0, 1'b1);
        dir(0, 1'b0, 3'b010, 'h010, 32'd0, 32'hDEAD55EF, 1'b0);
        dir(0, 1'b1, 3'b010, 'h020, 32'h11111111, 32'd0, 1'b0);
        wait_idle();

        // Store dropped by reset, once mid-wait and once on the access edge
        for (int dl = 0; dl < 2; dl++) begin
            issue(0, 1'b1, 3'b010, 'h020, 32'h22222222, 1'b0, 1'b1);
            if (dl == 1) @(negedge clk);
            rst[0] = 1'b1;
            expect_at(0, cyc + 1, 0, 32'd1, "rst_req_ready");
            expect_at(0, cyc + 1, 1, 32'd0, "rst_rsp_valid");
            expect_at(0, cyc + 1, 2, 32'd0, "rst_rsp_rdata");
            @(negedge clk);
            rst[0] = 1'b0;
            repeat (4) @(negedge clk);
            dir(0, 1'b0, 3'b010, 'h020, 32'd0, 32'h11111111, 1'b0);
            wait_idle();
        end

        for (int i = 0; i < 200; i++) begin
            a = $urandom_range(0, 63);
            issue(0, 1'($urandom), 3'($urandom), a, $urandom, 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();

        // WAIT_CYCLES=0 instance with req_valid held high throughout
        prev = 0;
        for (int i = 0; i < 120; i++) begin
            a = $urandom_range(0, 63);
            issue(1, 1'($urandom), 3'($urandom), a, $urandom, 1'b1, 1'b0);
            if (i > 0) expect_pre(1, cyc + 1, 32'(acc_edge - prev), 32'(W1 + 3), "b2b_accept_gap");
            prev = acc_edge;
        end
        v[1] = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
